vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port screen RAM between the 6502 core and the VGA renderer.
//  The CPU owns the RAM by default. On a video request, the CPU is drained to an
//  instruction boundary (SYNC) or a timeout, then stalled via RDY. Video owns the
//  RAM for the active line, then ownership returns to the CPU after one turnaround cycle.
//  The block sits between cpu bus decode, vga_render (screen_read_*) and generic_ram.
// PARAMETERS
//  ADDR_W     11  RAM address width (words)
//  DATA_W      8  RAM data width
//  DRAIN_MAX   7  max cycles in DRAIN waiting for cpu_sync before forced stall (>=1)
//  STAT_W     16  width of stall-cycle counter (ARB_STATS_EN only)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  cpu_req     in   1       CPU access to screen RAM window this cycle
//  cpu_we      in   1       CPU write strobe (qualified by cpu_req)
//  cpu_addr    in   ADDR_W  CPU word address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_sync    in   1       6502 SYNC: opcode fetch cycle (instruction boundary)
//  cpu_rdy     out  1       6502 RDY; 0 = CPU frozen
//  cpu_rdata   out  DATA_W  read data, valid 1 cycle after CPU read address
//  vid_req     in   1       renderer wants RAM (level, held for whole line)
//  vid_addr    in   ADDR_W  renderer read address
//  vid_grant   out  1       1 = video owns RAM; vid_addr is being applied
//  vid_rdata   out  DATA_W  read data, valid 1 cycle after granted vid_addr
//  mem_en      out  1       RAM read/write enable
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data (1-cycle synchronous read)
//  stall_cnt   out  STAT_W  stall cycle count (ARB_STATS_EN only)
// BEHAVIOUR
//  - Reset: state=CPU, cpu_rdy=1, vid_grant=0, drain counter=0, stall_cnt=0.
//    Reset applies from any state, including mid-VID. RAM contents are untouched.
//  - States and transitions (registered):
//    CPU   -> DRAIN when vid_req=1 and cpu_sync=0.
//    CPU   -> VID   when vid_req=1 and cpu_sync=1 (same-cycle boundary, skip drain).
//    DRAIN -> VID   when cpu_sync=1 or drain counter==DRAIN_MAX-1.
//    DRAIN -> CPU   when vid_req=0 (request withdrawn; no stall ever issued).
//    VID   -> REL   when vid_req=0.
//    REL   -> CPU   unconditionally (1 turnaround cycle, mem_en=0).
//  - The drain counter clears on DRAIN entry and increments each cycle in DRAIN.
//  - cpu_rdy is a registered output: 0 in VID and REL, 1 in CPU and DRAIN.
//    It drops on the same edge that enters VID.
//  - Mux in CPU and DRAIN: mem_addr=cpu_addr, mem_en=cpu_req, mem_we=cpu_req&cpu_we,
//    mem_wdata=cpu_wdata.
//  - Mux in VID: mem_addr=vid_addr, mem_en=1, mem_we=0.
//    CPU writes are never forwarded while cpu_rdy=0.
//  - vid_grant=1 only in VID. vid_rdata=cpu_rdata=mem_rdata (shared).
//    Each is meaningful only 1 cycle after its own owner's address.
//  - The last video read issued in VID completes during REL, so no CPU address
//    overlaps it.
//  - In VID, vid_req stays honoured whatever the CPU is doing; video has absolute priority.
//  - A vid_req re-asserted in REL is registered and enters DRAIN from CPU on the
//    next cycle.
// CONFIGURATION
//  ARB_STATS_EN defined: stall_cnt increments by 1 every cycle cpu_rdy=0, saturating
//    at all-ones. It clears on reset.
//  ARB_STATS_EN undefined: stall_cnt is tied to 0 and the counter is not synthesised.
//    All other behaviour is identical.
// TESTING
//  1. Reset, vid_req=0, CPU write 0x2A @0x200 then read -> mem_we pulse; cpu_rdata=0x2A
//     after 1 clk; cpu_rdy stays 1.
//  2. vid_req=1, cpu_sync pulses 3 clk later -> DRAIN 3 clk, then cpu_rdy=0 and
//     vid_grant=1 on the same edge; vid_addr 0x205 returns its data 1 clk later.
//  3. vid_req=1, cpu_sync held 0 (DRAIN_MAX=7) -> forced VID exactly 7 clk after DRAIN entry.
//  4. vid_req and cpu_sync asserted in the same cycle in CPU -> VID next edge, no DRAIN.
//     Drop vid_req -> 1 REL clk with mem_en=0, then cpu_rdy=1.
//  5. CPU asserts cpu_we in VID -> mem_we stays 0; RAM unchanged.
//     vid_req withdrawn during DRAIN -> back to CPU, cpu_rdy never 0.
//  6. reset asserted mid-VID -> next clk cpu_rdy=1, vid_grant=0, stall_cnt=0.
//     With ARB_STATS_EN, a 448-clk VID+REL window -> stall_cnt=448.

Source files
------------

// File: rtl/vram_arbiter.sv
// Screen RAM arbiter: shares one single-port RAM between the 6502 and the VGA renderer.
// Optional macro ARB_STATS_EN adds a saturating stall-cycle counter on stall_cnt.
module vram_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int DRAIN_MAX = 7,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_sync,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_grant,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stall_cnt
);

  // state | meaning
  // CPU   | CPU owns RAM, no video request pending
  // DRAIN | video pending, CPU runs on until SYNC or drain timeout
  // VID   | video owns RAM, CPU frozen via RDY
  // REL   | turnaround: last video read completes, RAM idle
  typedef enum logic [1:0] {S_CPU, S_DRAIN, S_VID, S_REL} state_t;

  localparam int CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CPU;
      cpu_rdy   <= 1'b1;
      vid_grant <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_CPU: begin
          if (vid_req) begin
            if (cpu_sync) begin
              state     <= S_VID;
              cpu_rdy   <= 1'b0;
              vid_grant <= 1'b1;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          // a withdrawn request wins over a coincident SYNC: no stall is issued
          if (!vid_req) begin
            state <= S_CPU;
          end else if (cpu_sync || drain_cnt == DRAIN_LAST) begin
            state     <= S_VID;
            cpu_rdy   <= 1'b0;
            vid_grant <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_VID: begin
          if (!vid_req) begin
            state     <= S_REL;
            vid_grant <= 1'b0;
          end
        end
        S_REL: begin
          state   <= S_CPU;
          cpu_rdy <= 1'b1;
        end
        default: begin
          state     <= S_CPU;
          cpu_rdy   <= 1'b1;
          vid_grant <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_en    = cpu_req;
    mem_we    = cpu_req & cpu_we;
    mem_wdata = cpu_wdata;
    case (state)
      S_VID: begin
        mem_addr = vid_addr;
        mem_en   = 1'b1;
        mem_we   = 1'b0;
      end
      S_REL: begin
        mem_en = 1'b0;
        mem_we = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign vid_rdata = mem_rdata;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!cpu_rdy && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM, shadow memory and a
// read-data scoreboard queue filled when reads are issued.
module tb_vram_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_sync, vid_req;
  logic [ADDR_W-1:0] cpu_addr, vid_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rdy, vid_grant, mem_en, mem_we;
  logic [DATA_W-1:0] cpu_rdata, vid_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [STAT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] shadow[int];
  logic [DATA_W-1:0] ram[0:(1<<ADDR_W)-1];

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_MAX(7), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_sync(cpu_sync), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag, input logic [DATA_W-1:0] obs);
    check_eq({tag, "_qdepth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) check_eq(tag, obs, exp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1 check_eq("cpu_wr_mem_we", mem_we, 1'b1);
    tick();
    shadow[int'(a)] = d;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    exp_q.push_back(shadow[int'(a)]);
    tick();
    cpu_req = 1'b0;
    sb_check("cpu_rdata", cpu_rdata);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_sync = 0; vid_req = 0;
    cpu_addr = '0; vid_addr = '0; cpu_wdata = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_eq("rst_cpu_rdy", cpu_rdy, 1'b1);
    check_eq("rst_vid_grant", vid_grant, 1'b0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    check_eq("rst_mem_en", mem_en, 1'b0);

    // 1: plain CPU access
    cpu_write(11'h200, 8'h2A);
    cpu_write(11'h205, 8'h5B);
    cpu_write(11'h206, 8'hC3);
    cpu_read(11'h200);
    cpu_read(11'h206);
    check_eq("t1_cpu_rdy", cpu_rdy, 1'b1);

    // 2: drain ended by SYNC after 3 cycles, then a video read
    vid_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_drain_rdy", cpu_rdy, 1'b1);
      check_eq("t2_drain_grant", vid_grant, 1'b0);
    end
    cpu_sync = 1'b1;
    tick();
    cpu_sync = 1'b0;
    check_eq("t2_vid_rdy", cpu_rdy, 1'b0);
    check_eq("t2_vid_grant", vid_grant, 1'b1);
    vid_addr = 11'h205;
    exp_q.push_back(shadow[32'h205]);
    #1 check_eq("t2_vid_mem_addr", mem_addr, 11'h205);
    tick();
    sb_check("t2_vid_rdata", vid_rdata);
    // 5a: CPU write attempt while frozen
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h206; cpu_wdata = 8'hFF;
    #1 check_eq("t5_vid_mem_we", mem_we, 1'b0);
    check_eq("t5_vid_mem_en", mem_en, 1'b1);
    vid_addr = 11'h206;
    exp_q.push_back(shadow[32'h206]);
    tick();
    sb_check("t5_vid_rdata", vid_rdata);
    vid_req = 1'b0;
    tick();
    check_eq("t5_rel_mem_en", mem_en, 1'b0);
    check_eq("t5_rel_rdy", cpu_rdy, 1'b0);
    check_eq("t5_rel_grant", vid_grant, 1'b0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    check_eq("t5_back_rdy", cpu_rdy, 1'b1);
    cpu_read(11'h206);

    // 3: forced stall after DRAIN_MAX cycles without SYNC
    vid_req = 1'b1;
    tick();
    for (int i = 1; i < 7; i++) begin
      tick();
      check_eq("t3_drain_rdy", cpu_rdy, 1'b1);
    end
    tick();
    check_eq("t3_forced_rdy", cpu_rdy, 1'b0);
    check_eq("t3_forced_grant", vid_grant, 1'b1);
    vid_req = 1'b0;
    repeat (2) tick();
    check_eq("t3_back_rdy", cpu_rdy, 1'b1);

    // 4: same-cycle SYNC skips DRAIN
    vid_req = 1'b1; cpu_sync = 1'b1;
    tick();
    cpu_sync = 1'b0;
    check_eq("t4_direct_grant", vid_grant, 1'b1);
    check_eq("t4_direct_rdy", cpu_rdy, 1'b0);
    vid_req = 1'b0;
    tick();
    check_eq("t4_rel_mem_en", mem_en, 1'b0);
    check_eq("t4_rel_rdy", cpu_rdy, 1'b0);
    tick();
    check_eq("t4_back_rdy", cpu_rdy, 1'b1);

    // 5b: request withdrawn during DRAIN
    vid_req = 1'b1;
    repeat (2) tick();
    vid_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t5_withdraw_rdy", cpu_rdy, 1'b1);
      check_eq("t5_withdraw_grant", vid_grant, 1'b0);
    end

    // 6: reset mid-VID, then a 448-cycle stall window
    vid_req = 1'b1; cpu_sync = 1'b1;
    tick();
    cpu_sync = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; vid_req = 1'b0;
    check_eq("t6_rst_rdy", cpu_rdy, 1'b1);
    check_eq("t6_rst_grant", vid_grant, 1'b0);
    check_eq("t6_rst_stall", stall_cnt, 0);
    tick();
    vid_req = 1'b1; cpu_sync = 1'b1;
    tick();
    cpu_sync = 1'b0;
    repeat (446) tick();
    vid_req = 1'b0;
    tick();
    tick();
    check_eq("t6_window_rdy", cpu_rdy, 1'b1);
`ifdef ARB_STATS_EN
    check_eq("t6_stall_cnt", stall_cnt, 448);
`else
    check_eq("t6_stall_cnt", stall_cnt, 0);
`endif
    cpu_read(11'h200);
    check_eq("end_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
